// File: rtl/t_counter_stage_pkg.sv
// Shared constants and types for the toggle-cell up/down counter.
package t_counter_stage_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 16;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

endpackage : t_counter_stage_pkg

// File: rtl/t_counter_stage_t_cell.sv
// Single toggle bit with synchronous active-low clear and a registered complement.
module t_cell (
    input  logic clk,
    input  logic clear,
    input  logic t,
    output logic q,
    output logic q_bar
);

    logic q_q;
    logic q_d;
    logic q_bar_q;

    always_comb q_d = q_q ^ t;

    // NOTE: state flops use non-blocking assignments so every cell samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!clear) begin
            q_q     <= 1'b0;
            q_bar_q <= 1'b1;
        end else begin
            q_q     <= q_d;
            q_bar_q <= ~q_d;
        end
    end

    assign q     = q_q;
    assign q_bar = q_bar_q;

endmodule : t_cell

// File: rtl/t_counter_stage.sv
// Modulo-N up/down counter built from t_cell toggle bits; drives tc for cascading and a wrap pulse.
// Optional parallel load is enabled by defining T_COUNTER_LOAD_EN.
module t_counter_stage
    import t_counter_stage_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
`ifdef T_COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] d,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    // One extra bit keeps MODULUS = 2^WIDTH representable in the compares.
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

    dir_e             dir;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic             load_act;
    logic             wrap_q;
    logic             wrap_d;

    assign dir   = dir_e'(up);
    assign q_ext = {1'b0, q};

`ifdef T_COUNTER_LOAD_EN
    logic [WIDTH:0] d_ext;
    assign d_ext    = {1'b0, d};
    assign load_act = load;
`else
    assign load_act = 1'b0;
`endif

    // NOTE: next_q is defaulted first so no path through this block infers a latch.
    always_comb begin
        next_q = q;
        if (load_act) begin
`ifdef T_COUNTER_LOAD_EN
            next_q = (d_ext >= MOD_W) ? WIDTH'(LAST_W) : d;
`endif
        end else if (en) begin
            if (dir == DIR_UP) begin
                next_q = (q_ext == LAST_W) ? '0 : WIDTH'(q_ext + ONE_W);
            end else begin
                next_q = (q_ext == '0) ? WIDTH'(LAST_W) : WIDTH'(q_ext - ONE_W);
            end
        end
    end

    // Each cell flips exactly the bits that differ between q and next_q.
    assign t = q ^ next_q;

    assign tc = en & (((dir == DIR_UP) & (q_ext == LAST_W)) |
                      ((dir == DIR_DOWN) & (q_ext == '0)));

    // A load replaces the count rather than wrapping it, so it suppresses the pulse.
    always_comb wrap_d = tc & ~load_act;

    always_ff @(posedge clk) begin
        if (!clear) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell u_cell (
            .clk   (clk),
            .clear (clear),
            .t     (t[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

endmodule : t_counter_stage

// File: tb/tb_t_counter_stage.sv
// Directed bench for t_counter_stage at WIDTH=4, MODULUS=10; load steps need T_COUNTER_LOAD_EN.
module tb_t_counter_stage;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         clear;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic [W-1:0] q_bar;
    logic         tc;
    logic         wrap;

    int checks = 0;
    int errors = 0;

    t_counter_stage #(.WIDTH(W), .MODULUS(M)) dut (
        .clk   (clk),
        .clear (clear),
        .en    (en),
        .up    (up),
`ifdef T_COUNTER_LOAD_EN
        .load  (load),
        .d     (d),
`endif
        .q     (q),
        .q_bar (q_bar),
        .tc    (tc),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; d = '0;

        // 1. reset held over two enabled edges
        tick(); tick();
        check("rst_q", q, 0);
        check("rst_qbar", q_bar, 4'hF);
        check("rst_wrap", wrap, 0);
        check("rst_tc", tc, 0);
        clear = 1'b1;
        tick();
        check("release_q", q, 1);

        // 2. up count to 9 then wrap to 0
        for (int i = 2; i <= 9; i++) begin
            tick();
            check("up_q", q, i);
            check("up_qbar", q_bar, ~i & 4'hF);
            check("up_wrap_low", wrap, 0);
        end
        check("up_tc_at9", tc, 1);
        tick();
        check("up_wrap_q", q, 0);
        check("up_wrap_pulse", wrap, 1);
        check("up_tc_at0", tc, 0);
        tick();
        check("up_after_q", q, 1);
        check("up_wrap_once", wrap, 0);

        // 3. down through zero, then flip direction
        tick();
        check("to2_q", q, 2);
        up = 1'b0;
        #1 check("dn_tc_at2", tc, 0);
        tick();
        check("dn_q1", q, 1);
        tick();
        check("dn_q0", q, 0);
        check("dn_tc_at0", tc, 1);
        check("dn_wrap_low", wrap, 0);
        tick();
        check("dn_q9", q, 9);
        check("dn_wrap_pulse", wrap, 1);
        check("dn_tc_at9", tc, 0);
        up = 1'b1;
        #1 check("flip_tc", tc, 1);
        tick();
        check("flip_q", q, 0);
        check("flip_wrap", wrap, 1);

        // 4. enable hold at 5
        repeat (5) tick();
        check("to5_q", q, 5);
        check("to5_wrap", wrap, 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_q", q, 5);
            check("hold_tc", tc, 0);
            check("hold_wrap", wrap, 0);
        end
        en = 1'b1;
        tick();
        check("resume_q", q, 6);

        // 5. reset mid-count, including at terminal count
        tick();
        check("to7_q", q, 7);
        clear = 1'b0;
        tick();
        check("midrst_q", q, 0);
        check("midrst_qbar", q_bar, 4'hF);
        check("midrst_wrap", wrap, 0);
        clear = 1'b1;
        repeat (9) tick();
        check("to9_q", q, 9);
        check("to9_tc", tc, 1);
        clear = 1'b0;
        tick();
        check("rst9_q", q, 0);
        check("rst9_wrap", wrap, 0);
        clear = 1'b1;

`ifdef T_COUNTER_LOAD_EN
        // 6. load clamps out-of-range data and never pulses wrap
        en = 1'b0; load = 1'b1; d = 4'd12;
        tick();
        check("ld_clamp_q", q, 9);
        check("ld_clamp_qbar", q_bar, 4'h6);
        check("ld_clamp_wrap", wrap, 0);
        en = 1'b1; d = 4'd3;
        #1 check("ld_tc_at9", tc, 1);
        tick();
        check("ld3_q", q, 3);
        check("ld3_wrap", wrap, 0);
        load = 1'b0;
        tick();
        check("ld_count_q", q, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_t_counter_stage

// File: doc/t_counter_stage.md
Name: t_counter_stage

Overview:
- Synchronous N-bit up/down counter built from a chain of toggle cells.
- Sits downstream of the single T flip-flop: bit i toggles when the generated per-bit toggle enable t[i] is high.
- Generates those toggle enables, a terminal-count flag for cascading, and a registered wrap pulse.
- Used as the counting core of later exercises, e.g. BCD digits and clock dividers from the 1 MHz clock.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 16, count range 0..MODULUS-1 (2..2^WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous reset, active-low; clear=0 at a rising edge resets.
- en  input  1  count enable; 0 holds state.
- up  input  1  direction; 1 counts up, 0 counts down.
- q  output  WIDTH  current count.
- q_bar  output  WIDTH  bitwise complement of q, registered alongside q.
- tc  output  1  terminal count, combinational.
- wrap  output  1  one-cycle registered pulse after a wrap.

Behaviour:
- Reset: clear=0 at a rising edge forces q=0, q_bar=all ones and wrap=0. Reset overrides en, up and load.
- Reset mid-count takes effect at that edge. The first count after reset release occurs at the first edge with clear=1 and en=1.
- Per-bit toggle vector: t = q XOR next_q. Each cell updates q[i] <= q[i] ^ t[i] and q_bar[i] <= ~(q[i] ^ t[i]).
- next_q when en=1 and up=1:
  - q==MODULUS-1 -> 0.
  - otherwise -> q+1.
- next_q when en=1 and up=0:
  - q==0 -> MODULUS-1.
  - otherwise -> q-1.
- When en=0: t=0 and q holds.
- Latency: one edge from en to the updated q. No pipeline.
- Direction change: up is sampled at every edge. A change applies at the same edge, with no dead cycle.
- tc = en & ((up & q==MODULUS-1) | (~up & q==0)). Purely combinational, so a higher-order counter can use tc as its en.
- wrap: registered copy of tc, high for exactly one cycle after the edge where the wrap occurred.
- For MODULUS = 2^WIDTH, wrap-around is natural binary overflow/underflow.
- Arithmetic: internal compare and increment are done at WIDTH+1 bits, so no truncation occurs at MODULUS = 2^WIDTH.
- Invariant: q never leaves 0..MODULUS-1.

Optional Feature:
- Macro: T_COUNTER_LOAD_EN.
- When defined, adds two ports:
  - load  input  1.
  - d  input  WIDTH.
- Load rules:
  - clear=1 and load=1 at an edge -> q<=d and q_bar<=~d, regardless of en.
  - If d>=MODULUS, the loaded value is MODULUS-1.
  - Load has priority over counting.
  - A load never asserts wrap. tc is evaluated on the current q, as usual.
- When not defined:
  - The load and d ports do not exist.
  - Counting follows the Behaviour section only.

Decomposition:
- Shared package holds:
  - localparam-style constants for the default WIDTH/MODULUS.
  - A direction enum: DIR_DOWN=0, DIR_UP=1.
- One sub-module: t_cell.
  - A single synchronous, active-low-clear toggle bit with ports clk, clear, t, q, q_bar.
  - Instantiated WIDTH times in a generate loop.
  - The top level contains only the next-state/toggle logic, tc, wrap and the optional load mux.

Test Plan (WIDTH=4, MODULUS=10):
1. Reset: hold clear=0 for 2 edges with en=1 -> q=0, q_bar=4'hF, wrap=0. Release clear -> q=1 after the first enabled edge.
2. Up wrap: en=1, up=1, count from 0 for 10 edges -> q sequence 1..9,0. tc=1 while q=9. wrap=1 for exactly the one cycle after q returns to 0.
3. Down wrap and direction flip: q=2, up=0, 3 edges -> q sequence 1,0,9. tc=1 while q=0. Then up=1 for 1 edge -> q=0.
4. Enable hold: q=5, en=0 for 5 edges -> q stays 5, tc=0, wrap=0. en=1 -> q=6 next edge.
5. Reset mid-operation: q=7, apply clear=0 together with en=1 and up=1 -> q=0 at that edge and no wrap pulse. Also, q=9 with clear=0 -> no wrap.
6. (T_COUNTER_LOAD_EN) load=1, d=4'd12 -> q=9. Then load=1, d=3 with en=1 -> q=3 and wrap stays 0.
